// File: rtl/irq_pkg.sv
// Shared constants, register map and FSM state type for the Minx interrupt controller.
package irq_pkg;

    localparam int NUM_IRQ    = 32;
    localparam int NUM_GROUPS = 8;

    localparam logic [23:0] IRQ_PRIO0 = 24'h002020;
    localparam logic [23:0] IRQ_PRIO1 = 24'h002021;
    localparam logic [23:0] IRQ_RSVD  = 24'h002022;
    localparam logic [23:0] IRQ_EN0   = 24'h002023;
    localparam logic [23:0] IRQ_EN1   = 24'h002024;
    localparam logic [23:0] IRQ_EN2   = 24'h002025;
    localparam logic [23:0] IRQ_EN3   = 24'h002026;
    localparam logic [23:0] IRQ_ACT0  = 24'h002027;
    localparam logic [23:0] IRQ_ACT1  = 24'h002028;
    localparam logic [23:0] IRQ_ACT2  = 24'h002029;
    localparam logic [23:0] IRQ_ACT3  = 24'h00202A;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_ACK  = 2'd1,
        IRQ_VEC  = 2'd2
    } irq_state_e;

    // Priority level 0 means "masked", so it never drives an irq line.
    function automatic logic [3:0] prio_onehot(input logic [1:0] p);
        logic [3:0] r;
        case (p)
            2'd1:    r = 4'b0010;
            2'd2:    r = 4'b0100;
            2'd3:    r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational arbiter: highest group priority wins, equal priorities go to the lowest source index.
module irq_arbiter
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0]      pending,
    input  logic [2*NUM_GROUPS-1:0] prio,
    output logic [4:0]              win_idx,
    output logic [1:0]              win_prio,
    output logic                    any
);

    always_comb begin
        win_idx  = '0;
        win_prio = '0;
        any      = 1'b0;
        // Ascending scan with strict '>' keeps the lowest index on ties.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending[i] && (!any || (prio[2*(i/4) +: 2] > win_prio))) begin
                any      = 1'b1;
                win_idx  = 5'(i);
                win_prio = prio[2*(i/4) +: 2];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Minx interrupt controller: source flags, enables, group priorities and the iack/vector handshake.
// Optional feature macro: IRQ_EDGE_DETECT_EN (level sources with rising-edge detection).
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [7:0] VEC_BASE = 8'h03
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pk,
    input  logic                 pl,
    input  logic                 cpu_write,
    input  logic                 cpu_read,
    input  logic [23:0]          address_in,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    input  logic [NUM_IRQ-1:0]   irq_sources,
    output logic [3:0]           irq,
    input  logic                 iack,
    input  logic                 read_interrupt_vector,
    output logic [7:0]           vector_out,
    output irq_state_e           state_dbg
);

    logic [2*NUM_GROUPS-1:0] prio_q, prio_d;
    logic [NUM_IRQ-1:0]      en_q, en_d;
    logic [NUM_IRQ-1:0]      act_q, act_d;
    logic [3:0]              irq_q, irq_d;
    logic [7:0]              vector_q, vector_d;
    logic [4:0]              idx_q, idx_d;
    logic                    spurious_q, spurious_d;
    irq_state_e              state_q, state_d;

    logic [NUM_IRQ-1:0]      set_vec;
    logic [NUM_IRQ-1:0]      clr_vec;
    logic [NUM_IRQ-1:0]      grp_live;
    logic [NUM_IRQ-1:0]      pending;
    logic [4:0]              win_idx;
    logic [1:0]              win_prio;
    logic                    win_any;
    logic                    wr_en;
    logic                    unused_pk;

    assign unused_pk = pk;
    assign wr_en     = cpu_write && pl;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] src_q, src_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q      <= '0;
            src_prev_q <= '0;
        end else begin
            src_q      <= irq_sources;
            src_prev_q <= src_q;
        end
    end

    assign set_vec = src_q & ~src_prev_q;
`else
    assign set_vec = irq_sources;
`endif

    always_comb begin
        prio_d  = prio_q;
        en_d    = en_q;
        clr_vec = '0;
        if (wr_en) begin
            case (address_in)
                IRQ_PRIO0: prio_d[7:0]   = data_in;
                IRQ_PRIO1: prio_d[15:8]  = data_in;
                IRQ_EN0:   en_d[7:0]     = data_in;
                IRQ_EN1:   en_d[15:8]    = data_in;
                IRQ_EN2:   en_d[23:16]   = data_in;
                IRQ_EN3:   en_d[31:24]   = data_in;
                IRQ_ACT0:  clr_vec[7:0]  = data_in;
                IRQ_ACT1:  clr_vec[15:8] = data_in;
                IRQ_ACT2:  clr_vec[23:16] = data_in;
                IRQ_ACT3:  clr_vec[31:24] = data_in;
                default: ;
            endcase
        end
        // Set is applied after clear so a coincident set wins.
        act_d = (act_q & ~clr_vec) | set_vec;
    end

    always_comb begin
        data_out = '0;
        if (cpu_read) begin
            case (address_in)
                IRQ_PRIO0: data_out = prio_q[7:0];
                IRQ_PRIO1: data_out = prio_q[15:8];
                IRQ_EN0:   data_out = en_q[7:0];
                IRQ_EN1:   data_out = en_q[15:8];
                IRQ_EN2:   data_out = en_q[23:16];
                IRQ_EN3:   data_out = en_q[31:24];
                IRQ_ACT0:  data_out = act_q[7:0];
                IRQ_ACT1:  data_out = act_q[15:8];
                IRQ_ACT2:  data_out = act_q[23:16];
                IRQ_ACT3:  data_out = act_q[31:24];
                default:   data_out = '0;
            endcase
        end
    end

    always_comb begin
        grp_live = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            grp_live[i] = |prio_q[2*(i/4) +: 2];
        end
    end

    assign pending = act_q & en_q & grp_live;

    irq_arbiter u_arbiter (
        .pending  (pending),
        .prio     (prio_q),
        .win_idx  (win_idx),
        .win_prio (win_prio),
        .any      (win_any)
    );

    always_comb begin
        state_d    = state_q;
        irq_d      = irq_q;
        vector_d   = vector_q;
        idx_d      = idx_q;
        spurious_d = spurious_q;
        case (state_q)
            IRQ_IDLE: begin
                irq_d = win_any ? prio_onehot(win_prio) : 4'b0000;
                if (iack) begin
                    idx_d      = win_any ? win_idx : 5'd0;
                    spurious_d = !win_any;
                    state_d    = IRQ_ACK;
                end
            end
            IRQ_ACK: begin
                if (read_interrupt_vector) begin
                    vector_d = spurious_q ? VEC_BASE : (VEC_BASE + {3'b000, idx_q});
                    state_d  = IRQ_VEC;
                end
            end
            IRQ_VEC: begin
                if (!read_interrupt_vector) begin
                    vector_d = '0;
                    state_d  = IRQ_IDLE;
                end
            end
            default: begin
                vector_d = '0;
                state_d  = IRQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q     <= '0;
            en_q       <= '0;
            act_q      <= '0;
            irq_q      <= '0;
            vector_q   <= '0;
            idx_q      <= '0;
            spurious_q <= 1'b0;
            state_q    <= IRQ_IDLE;
        end else begin
            prio_q     <= prio_d;
            en_q       <= en_d;
            act_q      <= act_d;
            irq_q      <= irq_d;
            vector_q   <= vector_d;
            idx_q      <= idx_d;
            spurious_q <= spurious_d;
            state_q    <= state_d;
        end
    end

    assign irq        = irq_q;
    assign vector_out = vector_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; expected values are queued by the stimulus and checked by a monitor.
module tb_irq_controller;
    import irq_pkg::*;

`ifdef IRQ_EDGE_DETECT_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pk = 1'b0;
    logic        pl = 1'b0;
    logic        cpu_write = 1'b0;
    logic        cpu_read = 1'b0;
    logic [23:0] address_in = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic [31:0] irq_sources = '0;
    logic [3:0]  irq;
    logic        iack = 1'b0;
    logic        read_interrupt_vector = 1'b0;
    logic [7:0]  vector_out;
    irq_state_e  state_dbg;

    logic        obs = 1'b0;
    logic        done = 1'b0;
    logic        drained = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [7:0]  rd_exp_q[$];
    logic [3:0]  irq_exp_q[$];
    logic [7:0]  vec_exp_q[$];
    logic [1:0]  st_exp_q[$];

    irq_controller #(.VEC_BASE(8'h03)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .pk                    (pk),
        .pl                    (pl),
        .cpu_write             (cpu_write),
        .cpu_read              (cpu_read),
        .address_in            (address_in),
        .data_in               (data_in),
        .data_out              (data_out),
        .irq_sources           (irq_sources),
        .irq                   (irq),
        .iack                  (iack),
        .read_interrupt_vector (read_interrupt_vector),
        .vector_out            (vector_out),
        .state_dbg             (state_dbg)
    );

    always #5 clk = ~clk;

    // Monitor: pops expectations whenever a read or an observation window is presented.
    always @(negedge clk) begin
        logic [7:0] e8;
        logic [3:0] e4;
        logic [1:0] e2;
        if (cpu_read) begin
            n_tests++;
            if (rd_exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected addr=%h got=%h", address_in, data_out);
            end else begin
                e8 = rd_exp_q.pop_front();
                if (data_out !== e8) begin
                    n_fail++;
                    $display("FAIL rd addr=%h got=%h exp=%h", address_in, data_out, e8);
                end
            end
        end
        if (obs) begin
            e4 = irq_exp_q.pop_front();
            e8 = vec_exp_q.pop_front();
            e2 = st_exp_q.pop_front();
            n_tests += 3;
            if (irq !== e4) begin
                n_fail++;
                $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e4);
            end
            if (vector_out !== e8) begin
                n_fail++;
                $display("FAIL vector_out t=%0t got=%h exp=%h", $time, vector_out, e8);
            end
            if (2'(state_dbg) !== e2) begin
                n_fail++;
                $display("FAIL state t=%0t got=%0d exp=%0d", $time, state_dbg, e2);
            end
        end
        if (done && !drained) begin
            drained <= 1'b1;
            n_tests++;
            if (rd_exp_q.size() + irq_exp_q.size() + vec_exp_q.size() + st_exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover_expectations got=%0d exp=0",
                         rd_exp_q.size() + irq_exp_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [23:0] addr, input logic [7:0] data);
        address_in = addr;
        data_in    = data;
        cpu_write  = 1'b1;
        pl         = 1'b1;
        tick();
        cpu_write  = 1'b0;
        pl         = 1'b0;
    endtask

    task automatic bus_read(input logic [23:0] addr, input logic [7:0] exp);
        address_in = addr;
        rd_exp_q.push_back(exp);
        cpu_read = 1'b1;
        @(negedge clk);
        #1;
        cpu_read = 1'b0;
    endtask

    task automatic observe(input logic [3:0] ei, input logic [7:0] ev, input irq_state_e es);
        irq_exp_q.push_back(ei);
        vec_exp_q.push_back(ev);
        st_exp_q.push_back(2'(es));
        obs = 1'b1;
        @(negedge clk);
        #1;
        obs = 1'b0;
    endtask

    task automatic pulse(input logic [31:0] mask);
        irq_sources = mask;
        tick();
        irq_sources = '0;
    endtask

    task automatic read_all_zero();
        for (int a = 'h2020; a <= 'h202A; a++) begin
            bus_read(24'(a), 8'h00);
        end
    endtask

    initial begin
        // Reset and register defaults
        repeat (3) tick();
        reset = 1'b0;
        tick();
        read_all_zero();
        observe(4'b0000, 8'h00, IRQ_IDLE);

        // Source 0 at group priority 3
        bus_write(IRQ_PRIO0, 8'h03);
        bus_write(IRQ_EN0, 8'h01);
        pulse(32'h0000_0001);
        repeat (LAT) tick();
        observe(4'b1000, 8'h00, IRQ_IDLE);
        bus_read(IRQ_ACT0, 8'h01);

        // W1C drops irq one edge later
        bus_write(IRQ_ACT0, 8'h01);
        tick();
        observe(4'b0000, 8'h00, IRQ_IDLE);

        // Priority tie between sources 5 and 9; reserved register ignores writes
        bus_write(IRQ_PRIO0, 8'h2B);
        bus_write(IRQ_RSVD, 8'hFF);
        bus_read(IRQ_RSVD, 8'h00);
        bus_read(IRQ_PRIO0, 8'h2B);
        bus_write(IRQ_EN0, 8'h21);
        bus_write(IRQ_EN1, 8'h02);
        pulse(32'h0000_0220);
        repeat (LAT) tick();
        observe(4'b0100, 8'h00, IRQ_IDLE);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        observe(4'b0100, 8'h00, IRQ_ACK);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        bus_write(IRQ_ACT0, 8'h20);
        tick();
        observe(4'b0100, 8'h00, IRQ_ACK);
        read_interrupt_vector = 1'b1;
        tick();
        observe(4'b0100, 8'h08, IRQ_VEC);
        tick();
        observe(4'b0100, 8'h08, IRQ_VEC);
        read_interrupt_vector = 1'b0;
        tick();
        observe(4'b0100, 8'h00, IRQ_IDLE);

        // Coincident set and W1C clear of source 0 resolves to set
`ifdef IRQ_EDGE_DETECT_EN
        pulse(32'h0000_0001);
        bus_write(IRQ_ACT0, 8'h01);
`else
        irq_sources = 32'h0000_0001;
        bus_write(IRQ_ACT0, 8'h01);
        irq_sources = '0;
`endif
        bus_read(IRQ_ACT0, 8'h01);
        bus_read(IRQ_ACT1, 8'h02);
        tick();
        observe(4'b1000, 8'h00, IRQ_IDLE);

        // Spurious acknowledge with nothing pending
        bus_write(IRQ_ACT0, 8'h01);
        bus_write(IRQ_ACT1, 8'h02);
        tick();
        observe(4'b0000, 8'h00, IRQ_IDLE);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        observe(4'b0000, 8'h00, IRQ_ACK);
        read_interrupt_vector = 1'b1;
        tick();
        observe(4'b0000, 8'h03, IRQ_VEC);
        read_interrupt_vector = 1'b0;
        tick();
        observe(4'b0000, 8'h00, IRQ_IDLE);

        // Asynchronous reset while in VEC
        pulse(32'h0000_0200);
        repeat (LAT) tick();
        observe(4'b0100, 8'h00, IRQ_IDLE);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        read_interrupt_vector = 1'b1;
        tick();
        observe(4'b0100, 8'h0C, IRQ_VEC);
        tick();
        reset = 1'b1;
        observe(4'b0000, 8'h00, IRQ_IDLE);
        reset = 1'b0;
        read_interrupt_vector = 1'b0;
        tick();
        read_all_zero();
        observe(4'b0000, 8'h00, IRQ_IDLE);

        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
